// File: rtl/traffic_light_timed_ctrl.sv
// Timed highway/country intersection controller with all-red clearance, latched pedestrian
// walk request and a flashing-yellow fault mode. All outputs are a Moore decode of state.
module traffic_light_timed_ctrl #(
    parameter int unsigned CNT_W           = 8,
    parameter int unsigned HWY_GREEN_MIN   = 8,
    parameter int unsigned YELLOW_TIME     = 3,
    parameter int unsigned ALLRED_TIME     = 2,
    parameter int unsigned CNTRY_GREEN_MIN = 4,
    parameter int unsigned CNTRY_GREEN_MAX = 10,
    parameter int unsigned PED_WALK_TIME   = 6,
    parameter int unsigned FLASH_HALF      = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       x,
    input  logic       ped_req,
    input  logic       flash,
    output logic [2:0] hwy,
    output logic [2:0] cntry,
    output logic       ped_walk,
    output logic [2:0] state_o
);

    localparam int unsigned WalkGreenMin =
        (PED_WALK_TIME > CNTRY_GREEN_MIN) ? PED_WALK_TIME : CNTRY_GREEN_MIN;

    // Exit thresholds: a dwell of N cycles ends when the timer reads N-1.
    localparam logic [CNT_W-1:0] HgLast     = CNT_W'(HWY_GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] YelLast    = CNT_W'(YELLOW_TIME - 1);
    localparam logic [CNT_W-1:0] ArLast     = CNT_W'(ALLRED_TIME - 1);
    localparam logic [CNT_W-1:0] CgMinLast  = CNT_W'(CNTRY_GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] CgWalkLast = CNT_W'(WalkGreenMin - 1);
    localparam logic [CNT_W-1:0] CgMaxLast  = CNT_W'(CNTRY_GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] FlashLast  = CNT_W'(FLASH_HALF - 1);

    localparam logic [2:0] LampOff    = 3'b000;
    localparam logic [2:0] LampRed    = 3'b001;
    localparam logic [2:0] LampYellow = 3'b010;
    localparam logic [2:0] LampGreen  = 3'b100;

    typedef enum logic [2:0] {
        StHg    = 3'd0,
        StHy    = 3'd1,
        StAr1   = 3'd2,
        StCg    = 3'd3,
        StCy    = 3'd4,
        StAr2   = 3'd5,
        StFlash = 3'd6,
        StBad   = 3'd7
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             ped_pend_q, ped_pend_d;
    logic             ped_walk_q, ped_walk_d;
    logic             blink_q, blink_d;
    logic             start_walk;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StHg;
            timer_q    <= '0;
            ped_pend_q <= 1'b0;
            ped_walk_q <= 1'b0;
            blink_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            ped_pend_q <= ped_pend_d;
            ped_walk_q <= ped_walk_d;
            blink_q    <= blink_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flash) begin
            state_d = StFlash;
        end else begin
            case (state_q)
                StHg:    if (timer_q >= HgLast && (x || ped_pend_q || ped_req)) state_d = StHy;
                StHy:    if (timer_q == YelLast) state_d = StAr1;
                StAr1:   if (timer_q == ArLast) state_d = StCg;
                StCg: begin
                    if (timer_q == CgMaxLast ||
                        (!x && timer_q >= (ped_walk_q ? CgWalkLast : CgMinLast))) begin
                        state_d = StCy;
                    end
                end
                StCy:    if (timer_q == YelLast) state_d = StAr2;
                StAr2:   if (timer_q == ArLast) state_d = StHg;
                StFlash: state_d = StAr2;
                default: state_d = StHg;
            endcase
        end
    end

    always_comb begin
        timer_d    = timer_q;
        blink_d    = blink_q;
        ped_pend_d = ped_pend_q;
        ped_walk_d = ped_walk_q;
        start_walk = (state_q == StAr1) && (state_d == StCg);

        if (state_d != state_q) begin
            timer_d = '0;
        end else if (state_q == StFlash && timer_q == FlashLast) begin
            timer_d = '0;
            blink_d = ~blink_q;
        end else if (timer_q != '1) begin
            timer_d = timer_q + 1'b1;
        end
        if (state_d == StFlash && state_q != StFlash) begin
            blink_d = 1'b1;
        end

        // A request arriving on the cycle green starts is served now, not left pending.
        if (start_walk) begin
            ped_pend_d = 1'b0;
            ped_walk_d = ped_pend_q | ped_req;
        end else begin
            if (ped_req) ped_pend_d = 1'b1;
            if (state_d != StCg) ped_walk_d = 1'b0;
        end
    end

    always_comb begin
        hwy      = LampRed;
        cntry    = LampRed;
        ped_walk = 1'b0;
        state_o  = state_q;
        case (state_q)
            StHg:  hwy = LampGreen;
            StHy:  hwy = LampYellow;
            StCg: begin
                cntry    = LampGreen;
                ped_walk = ped_walk_q;
            end
            StCy:  cntry = LampYellow;
            StFlash: begin
                hwy   = blink_q ? LampYellow : LampOff;
                cntry = blink_q ? LampYellow : LampOff;
            end
            default: ;
        endcase
    end

endmodule
